// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational 16-bit ALU between two
// valid/ready requesters. Round-robin arbitration in IDLE, registered operand
// issue, result capture in EXEC and a one-cycle tagged response in RESP.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins contention).
module alu_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  input  logic             req_valid1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             req_ready0,
  output logic             req_ready1,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_id_q;
  logic   id_q;
  logic   gnt_valid;
  logic   gnt_id;

  // Grant decision: only in IDLE, recomputed every cycle, nothing remembered.
  // Readies are held low while reset is asserted so all outputs read 0.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req_valid0 && req_valid1) begin
        gnt_valid = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt_id    = 1'b0;
`else
        gnt_id    = ~last_id_q;
`endif
      end else if (req_valid0) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req_valid1) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
    req_ready0 = gnt_valid & ~gnt_id;
    req_ready1 = gnt_valid & gnt_id;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d    = state_q;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (gnt_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand issue on handshake, result capture at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id_q <= 1'b1;
      id_q      <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      resp_id   <= 1'b0;
      resp_data <= '0;
      resp_zero <= 1'b0;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        alu_op    <= gnt_id ? req_op1 : req_op0;
        alu_a     <= gnt_id ? req_a1  : req_a0;
        alu_b     <= gnt_id ? req_b1  : req_b0;
        id_q      <= gnt_id;
        last_id_q <= gnt_id;
      end
      if (state_q == EXEC) begin
        resp_data <= alu_y;
        resp_zero <= (alu_y == '0);
        resp_id   <= id_q;
      end
    end
  end

endmodule
